// File: rtl/codificador_7seg_binario.sv
// Multiplexed 7-segment display decoder: recovers the binary digit shown at
// each of four positions once the sampled bus has been stable long enough.
module codificador_7seg_binario #(
  parameter int N_ESTABLE = 4
) (
  input  logic        i_Clk,
  input  logic        i_Reset,
  input  logic [6:0]  i_Segmentos,
  input  logic [3:0]  i_Anodos,
  output logic [3:0]  o_Digito,
  output logic [1:0]  o_Posicion,
  output logic        o_Valido,
  output logic        o_Error,
  output logic [15:0] o_Valores
);

  localparam int CW = $clog2(N_ESTABLE + 1);
  localparam logic [CW-1:0] N_C = CW'(N_ESTABLE);
  localparam logic [CW-1:0] UNO = CW'(1);

  typedef enum logic [1:0] {
    ESPERA,
    VERIFICA,
    REPORTA,
    BLOQUEO
  } estado_t;

  // {valid, position} of a strobe word; valid only for a single low bit
  function automatic logic [2:0] dec_an(
    input logic [3:0] an
  );
    logic [2:0] r;
    case (an)
      4'b1110: r = 3'b100;
      4'b1101: r = 3'b101;
      4'b1011: r = 3'b110;
      4'b0111: r = 3'b111;
      default: r = 3'b000;
    endcase
    return r;
  endfunction

  // {recognised, value} of an active-low segment pattern
  function automatic logic [4:0] dec_seg(
    input logic [6:0] seg
  );
    logic [4:0] r;
    case (seg)
      7'b0000001: r = 5'h10;
      7'b1001111: r = 5'h11;
      7'b0010010: r = 5'h12;
      7'b0000110: r = 5'h13;
      7'b1001100: r = 5'h14;
      7'b0100100: r = 5'h15;
      7'b0100000: r = 5'h16;
      7'b0001111: r = 5'h17;
      7'b0000000: r = 5'h18;
      7'b0001100: r = 5'h19;
      7'b0001000: r = 5'h1A;
      7'b1100000: r = 5'h1B;
      7'b0110001: r = 5'h1C;
      7'b1000010: r = 5'h1D;
      7'b0110000: r = 5'h1E;
      7'b0111000: r = 5'h1F;
      default:    r = 5'h00;
    endcase
    return r;
  endfunction

  logic [10:0]   s_q;
  logic [10:0]   pat_q;
  logic [10:0]   pat_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  estado_t       est_q;
  estado_t       est_d;

  logic [3:0]  dig_q;
  logic [3:0]  dig_d;
  logic [1:0]  pos_q;
  logic [1:0]  pos_d;
  logic        val_q;
  logic        val_d;
  logic        err_q;
  logic        err_d;
  logic [15:0] vals_q;
  logic [15:0] vals_d;

  logic [2:0] s_an;
  logic [2:0] p_an;
  logic [4:0] p_seg;
  logic       s_uno;
  logic       cambio;

  assign s_an   = dec_an(s_q[10:7]);
  assign s_uno  = s_an[2];
  assign p_an   = dec_an(pat_q[10:7]);
  assign p_seg  = dec_seg(pat_q[6:0]);
  // pat_q always holds the previous sample while a run is being counted
  assign cambio = (s_q != pat_q);

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      est_q <= ESPERA;
      cnt_q <= '0;
      s_q   <= 11'h7FF;
      pat_q <= 11'h7FF;
    end else begin
      est_q <= est_d;
      cnt_q <= cnt_d;
      s_q   <= {i_Anodos, i_Segmentos};
      pat_q <= pat_d;
    end
  end

  always_comb begin
    est_d = est_q;
    cnt_d = cnt_q;
    pat_d = pat_q;
    case (est_q)
      ESPERA: begin
        pat_d = s_q;
        if (s_uno) begin
          est_d = VERIFICA;
          cnt_d = UNO;
        end
      end
      VERIFICA: begin
        if (cambio) begin
          pat_d = s_q;
          cnt_d = UNO;
          est_d = s_uno ? VERIFICA : ESPERA;
        end else if (cnt_q == N_C - UNO) begin
          cnt_d = N_C;
          est_d = REPORTA;
        end else begin
          cnt_d = cnt_q + UNO;
        end
      end
      REPORTA: begin
        est_d = BLOQUEO;
      end
      BLOQUEO: begin
        if (cambio) begin
          pat_d = s_q;
          cnt_d = UNO;
          est_d = s_uno ? VERIFICA : ESPERA;
        end
      end
      default: begin
        est_d = ESPERA;
        cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    dig_d  = dig_q;
    pos_d  = pos_q;
    val_d  = 1'b0;
    err_d  = 1'b0;
    vals_d = vals_q;
    if (est_q == REPORTA) begin
      pos_d = p_an[1:0];
      if (p_seg[4]) begin
        val_d = 1'b1;
        dig_d = p_seg[3:0];
        vals_d[{p_an[1:0], 2'b00} +: 4] = p_seg[3:0];
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      dig_q  <= '0;
      pos_q  <= '0;
      val_q  <= 1'b0;
      err_q  <= 1'b0;
      vals_q <= '0;
    end else begin
      dig_q  <= dig_d;
      pos_q  <= pos_d;
      val_q  <= val_d;
      err_q  <= err_d;
      vals_q <= vals_d;
    end
  end

  assign o_Digito   = dig_q;
  assign o_Posicion = pos_q;
  assign o_Valido   = val_q;
  assign o_Error    = err_q;
  assign o_Valores  = vals_q;

endmodule

// File: doc/codificador_7seg_binario.md
CODIFICADOR_7SEG_BINARIO -- requirements
Module: codificador_7seg_binario

Interface
REQ-001 Parameter: N_ESTABLE, default 4, number of consecutive identical samples required before a digit is accepted (legal range 2..15).
REQ-002 i_Clk  input  1  system clock; all state changes on the rising edge.
REQ-003 i_Reset  input  1  asynchronous, active-high reset.
REQ-004 i_Segmentos  input  7  segment bus, active-low (0 = lit); bit6 = a, bit5 = b, ... bit0 = g.
REQ-005 i_Anodos  input  4  digit strobes, active-low; exactly one low bit selects digit 0..3 (bit0 = digit 0).
REQ-006 o_Digito  output  4  binary value of the last accepted digit.
REQ-007 o_Posicion  output  2  position (0..3) of the last accepted or rejected digit.
REQ-008 o_Valido  output  1  one-cycle pulse: o_Digito/o_Posicion were updated with a recognised pattern.
REQ-009 o_Error  output  1  one-cycle pulse: a stable pattern was not in the code table.
REQ-010 o_Valores  output  16  stored digits; nibble [4p+3:4p] holds digit at position p.

Function
REQ-011 Both inputs SHALL be registered once (sample register S = {anodos, segmentos}) before any decision.
REQ-012 Code table (i_Segmentos -> value) SHALL be: 0000001->0, 1001111->1, 0010010->2, 0000110->3, 1001100->4, 0100100->5, 0100000->6, 0001111->7, 0000000->8, 0001100->9, 0001000->A, 1100000->B, 0110001->C, 1000010->D, 0110000->E, 0111000->F.
REQ-013 FSM states SHALL be ESPERA, VERIFICA, REPORTA, BLOQUEO.
- ESPERA: S anodes not one-hot-low -> stay; one-hot-low -> VERIFICA, run counter = 1.
REQ-014 VERIFICA: S unchanged from previous cycle -> counter +1; S changed -> counter = 1 (stay in VERIFICA if one-hot-low, else ESPERA); counter reaching N_ESTABLE -> REPORTA.
REQ-015 REPORTA (exactly one cycle): recognised pattern -> o_Valido = 1, o_Digito = value, o_Posicion = p, o_Valores nibble p = value; unrecognised -> o_Error = 1, o_Posicion = p, o_Digito and o_Valores unchanged; then BLOQUEO.
REQ-016 BLOQUEO: no further report while S is unchanged; any change of S -> VERIFICA (counter = 1) if one-hot-low, else ESPERA.
REQ-017 Latency: inputs constant before rising edge k -> pulse visible in the cycle after edge k+N_ESTABLE+1 (one sample stage, N_ESTABLE counts, one report stage).
REQ-018 o_Valido and o_Error SHALL never be high in the same cycle and SHALL never stay high longer than one cycle.
REQ-019 All-high anodes (blanking) or multiple low anodes SHALL produce no pulse and SHALL not modify o_Valores.
REQ-020 Counter SHALL saturate-free: width ceil(log2(N_ESTABLE+1)), never wraps, cleared on any S change.
REQ-021 Segment change with unchanged anodes SHALL restart stability counting (a glitch shorter than N_ESTABLE samples is never reported).

Reset
REQ-022 i_Reset high SHALL immediately force: FSM = ESPERA, counter = 0, S = {4'b1111, 7'b1111111}, o_Digito = 0, o_Posicion = 0, o_Valido = 0, o_Error = 0, o_Valores = 16'h0000.
REQ-023 Reset asserted mid-VERIFICA or during REPORTA SHALL suppress the pending pulse; counting restarts only after reset release.

Verification
REQ-024 N_ESTABLE=4, anodes 1110, segments 0000110 held 10 cycles -> single o_Valido pulse, o_Digito = 3, o_Posicion = 0, o_Valores = 16'h0003, no second pulse.
REQ-025 Scan 1110/0010010, 1101/1001111, 1011/0001000, 0111/0111000, 6 cycles each -> four o_Valido pulses, final o_Valores = 16'hFA12.
REQ-026 Anodes 1101, segments 1111110 held 8 cycles -> one o_Error pulse, o_Posicion = 1, o_Valores unchanged.
REQ-027 Anodes 1110, segments 0000000 for 2 cycles then 1001111 for 6 cycles -> no pulse for 8, one o_Valido with o_Digito = 1.
REQ-028 Anodes 1100 or 1111 with segments 0000001 for 10 cycles -> no o_Valido, no o_Error; reset asserted at cycle 3 of a valid 4-cycle run -> no pulse, all outputs at reset values.
